// File: rtl/data_sram_resp.sv
// Data-side SRAM responder: single-outstanding load/store with byte strobes and a
// fixed LATENCY-cycle data_ok response. Define DSRAM_RESP_OOR_EN for out-of-range error reporting.
module data_sram_resp #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
`ifdef DSRAM_RESP_OOR_EN
  ,
  output logic        data_sram_err
`endif
);

  localparam int       DEPTH  = 1 << ADDR_WIDTH;
  localparam bit [2:0] LAT_M1 = 3'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [31:0]             mem [DEPTH];
  logic [ADDR_WIDTH-1:0]   idx;
  logic                    accept;
  logic                    oor;
  logic                    mem_we;

  assign idx = data_sram_addr[ADDR_WIDTH+1:2];

`ifdef DSRAM_RESP_OOR_EN
  assign oor = |data_sram_addr[31:ADDR_WIDTH+2];
  logic unused_addr_bits;
  assign unused_addr_bits = ^data_sram_addr[1:0];
`else
  assign oor = 1'b0;
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_sram_addr[1:0], data_sram_addr[31:ADDR_WIDTH+2]};
`endif

  assign accept = data_sram_req && data_sram_addr_ok;
  // Array has no reset; keep writes out while reset is held so a held req cannot commit.
  assign mem_we = accept && data_sram_wr && !oor && !reset;

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    rdata_d           = rdata_q;
    err_d             = err_q;
    data_sram_addr_ok = (state_q != S_WAIT);

    case (state_q)
      S_IDLE: ;
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Acceptance only happens in IDLE/RESP, so it may override the RESP->IDLE default.
    if (accept) begin
      cnt_d   = LAT_M1;
      state_d = (LAT_M1 == 3'd0) ? S_RESP : S_WAIT;
      rdata_d = (!data_sram_wr && !oor) ? mem[idx] : '0;
      err_d   = oor;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

  assign data_sram_data_ok = (state_q == S_RESP);
  assign data_sram_rdata   = data_sram_data_ok ? rdata_q : '0;

`ifdef DSRAM_RESP_OOR_EN
  assign data_sram_err = data_sram_data_ok && err_q;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: three instances (LATENCY 1, 3, 4) driven one at a time,
// expected responses queued at issue and checked when data_ok fires.
module tb_data_sram_resp;

  localparam int AW   = 10;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NDUT-1:0] rst, req, wr, addr_ok, data_ok, err;
  logic [3:0]      wstrb [NDUT];
  logic [31:0]     addr  [NDUT];
  logic [31:0]     wdata [NDUT];
  logic [31:0]     rdata [NDUT];

  data_sram_resp #(.ADDR_WIDTH(AW), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .reset(rst[0]), .data_sram_req(req[0]), .data_sram_wr(wr[0]),
    .data_sram_wstrb(wstrb[0]), .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
    .data_sram_addr_ok(addr_ok[0]), .data_sram_data_ok(data_ok[0]), .data_sram_rdata(rdata[0])
`ifdef DSRAM_RESP_OOR_EN
    , .data_sram_err(err[0])
`endif
  );

  data_sram_resp #(.ADDR_WIDTH(AW), .LATENCY(3)) u_dut_l3 (
    .clk(clk), .reset(rst[1]), .data_sram_req(req[1]), .data_sram_wr(wr[1]),
    .data_sram_wstrb(wstrb[1]), .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
    .data_sram_addr_ok(addr_ok[1]), .data_sram_data_ok(data_ok[1]), .data_sram_rdata(rdata[1])
`ifdef DSRAM_RESP_OOR_EN
    , .data_sram_err(err[1])
`endif
  );

  data_sram_resp #(.ADDR_WIDTH(AW), .LATENCY(4)) u_dut_l4 (
    .clk(clk), .reset(rst[2]), .data_sram_req(req[2]), .data_sram_wr(wr[2]),
    .data_sram_wstrb(wstrb[2]), .data_sram_addr(addr[2]), .data_sram_wdata(wdata[2]),
    .data_sram_addr_ok(addr_ok[2]), .data_sram_data_ok(data_ok[2]), .data_sram_rdata(rdata[2])
`ifdef DSRAM_RESP_OOR_EN
    , .data_sram_err(err[2])
`endif
  );

`ifndef DSRAM_RESP_OOR_EN
  assign err = '0;
`endif

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  typedef struct {
    int          d;
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [NDUT][1 << AW];
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response monitor per instance, sampling on the falling edge.
  for (genvar g = 0; g < NDUT; g++) begin : g_mon
    always @(negedge clk) begin
      if (data_ok[g]) begin
        if (sb.size() != 0 && sb[0].d == g) begin
          check_eq($sformatf("rdata_d%0d", g), rdata[g], sb[0].rdata);
          check_eq($sformatf("err_d%0d", g), 32'(err[g]), 32'(sb[0].err));
          check_eq($sformatf("resp_cycle_d%0d", g), 32'(cyc), 32'(sb[0].cyc));
          void'(sb.pop_front());
        end else begin
          check_eq($sformatf("spurious_data_ok_d%0d", g), 32'(data_ok[g]), 32'd0);
        end
      end else begin
        check_eq($sformatf("rdata_idle_d%0d", g), rdata[g], 32'd0);
        check_eq($sformatf("err_idle_d%0d", g), 32'(err[g]), 32'd0);
        if (sb.size() != 0 && sb[0].d == g && sb[0].cyc <= cyc) begin
          check_eq($sformatf("missed_data_ok_d%0d", g), 32'(data_ok[g]), 32'd1);
          void'(sb.pop_front());
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the acceptance edge.
  task automatic issue(input int d, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] st, output int stalls);
    exp_t             e;
    logic [AW-1:0]    idx;
    logic             oor;
    req[d]   = 1'b1;
    wr[d]    = w;
    addr[d]  = a;
    wdata[d] = wd;
    wstrb[d] = st;
    stalls   = 0;
    while (!addr_ok[d] && stalls < 20) begin
      @(negedge clk);
      stalls++;
    end
    if (!addr_ok[d]) begin
      check_eq("addr_ok_timeout", 32'(addr_ok[d]), 32'd1);
      req[d] = 1'b0;
      return;
    end
    idx = a[AW+1:2];
`ifdef DSRAM_RESP_OOR_EN
    oor = |a[31:AW+2];
`else
    oor = 1'b0;
`endif
    e.d   = d;
    e.cyc = cyc + lat_of(d);
    e.err = oor;
    if (w) begin
      if (!oor)
        for (int b = 0; b < 4; b++)
          if (st[b]) model[d][idx][8*b +: 8] = wd[8*b +: 8];
      e.rdata = '0;
    end else begin
      e.rdata = oor ? 32'h0 : model[d][idx];
    end
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req[d] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    rst = '1;
    req = '0;
    wr  = '0;
    for (int d = 0; d < NDUT; d++) begin
      addr[d]  = '0;
      wdata[d] = '0;
      wstrb[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      check_eq($sformatf("reset_addr_ok_d%0d", d), 32'(addr_ok[d]), 32'd1);
      check_eq($sformatf("reset_data_ok_d%0d", d), 32'(data_ok[d]), 32'd0);
      check_eq($sformatf("reset_rdata_d%0d", d), rdata[d], 32'd0);
    end
    rst = '0;
    @(negedge clk);

    // LATENCY=1 store/load, back-to-back through RESP
    issue(0, 1'b1, 32'h10, 32'hA5A5_1234, 4'hF, s);
    issue(0, 1'b0, 32'h10, 32'h0, 4'h0, s);
    check_eq("b2b_stall_l1", 32'(s), 32'd0);
    drain();

    // Byte strobes
    issue(0, 1'b1, 32'h20, 32'h1111_1111, 4'hF, s);
    issue(0, 1'b1, 32'h20, 32'hFFEE_DDCC, 4'b0101, s);
    issue(0, 1'b0, 32'h22, 32'h0, 4'h0, s);
    drain();

    // LATENCY=3: req held, acceptance only on the RESP edge
    issue(1, 1'b1, 32'h10, 32'h0BAD_F00D, 4'hF, s);
    drain();
    issue(1, 1'b0, 32'h10, 32'h0, 4'h0, s);
    check_eq("first_stall_l3", 32'(s), 32'd0);
    issue(1, 1'b0, 32'h10, 32'h0, 4'h0, s);
    check_eq("b2b_stall_l3", 32'(s), 32'd2);
    issue(1, 1'b1, 32'h14, 32'h1234_5678, 4'hF, s);
    check_eq("b2b_stall_l3_st", 32'(s), 32'd2);
    drain();

    // Zero strobe leaves the array alone
    issue(1, 1'b1, 32'h30, 32'h0000_0007, 4'hF, s);
    issue(1, 1'b1, 32'h30, 32'hFFFF_FFFF, 4'h0, s);
    issue(1, 1'b0, 32'h30, 32'h0, 4'h0, s);
    drain();

    // Reset mid-WAIT on LATENCY=4: response dropped, store kept
    issue(2, 1'b1, 32'h40, 32'hDEAD_0001, 4'hF, s);
    @(negedge clk);
    #2;
    rst[2] = 1'b1;
    sb.delete();
    #1;
    check_eq("rst_addr_ok", 32'(addr_ok[2]), 32'd1);
    check_eq("rst_data_ok", 32'(data_ok[2]), 32'd0);
    @(negedge clk);
    rst[2] = 1'b0;
    repeat (6) @(negedge clk);
    issue(2, 1'b0, 32'h40, 32'h0, 4'h0, s);
    drain();

    // Upper address bits: error when range checking is built in, alias otherwise
    issue(0, 1'b1, 32'h0, 32'h1357_9BDF, 4'hF, s);
    issue(0, 1'b1, 32'h0000_1000, 32'hCAFE_BABE, 4'hF, s);
    issue(0, 1'b0, 32'h0, 32'h0, 4'h0, s);
    issue(0, 1'b0, 32'h8000_1004, 32'h0, 4'h0, s);
    drain();

    // Random traffic on every instance over a preloaded window
    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 16; i++) issue(d, 1'b1, 32'(i * 4), $urandom, 4'hF, s);
      for (int i = 0; i < 40; i++) begin
        logic [31:0] a;
        a = {20'h0, 6'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
        if ($urandom_range(0, 3) == 0) a[31:12] = 20'($urandom);
        issue(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), s);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
